// File: rtl/branch_predictor.sv
// Branch direction predictor with three selectable schemes: static
// not-taken, bimodal and gshare. There is one table of saturating counters,
// read combinationally at lookup and written once per cycle from the
// resolved-branch update port. Two saturating event counters (lookups and
// mispredictions) are also kept.
module branch_predictor #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned MODE       = 1,
  parameter int unsigned GHR_BITS   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_lookup_valid,
  input  logic [PC_WIDTH-1:0] i_lookup_pc,
  output logic                o_predict_taken,
  input  logic                i_update_valid,
  input  logic [PC_WIDTH-1:0] i_update_pc,
  input  logic                i_update_taken,
  input  logic                i_update_mispredict,
  output logic [31:0]         o_lookup_count,
  output logic [31:0]         o_mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]   table_q [ENTRIES];
  logic [GHR_BITS-1:0]   ghr_q;
  logic [INDEX_BITS-1:0] ghr_mix;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [CTR_BITS-1:0]   update_ctr;
  logic [CTR_BITS-1:0]   update_ctr_next;
  logic                  unused_bits;

  // PC bits outside the index field never take part in indexing.
  assign unused_bits = ^{i_lookup_pc, i_update_pc, ghr_q};

  // Index formation: the PC word index, hashed with history in gshare mode.
  always_comb begin
    ghr_mix    = (MODE == 2) ? INDEX_BITS'(ghr_q) : '0;
    lookup_idx = i_lookup_pc[INDEX_BITS+1:2] ^ ghr_mix;
    update_idx = i_update_pc[INDEX_BITS+1:2] ^ ghr_mix;
  end

  // Prediction is the counter MSB of the registered table, with no bypass.
  always_comb begin
    o_predict_taken = 1'b0;
    if (MODE != 0 && i_lookup_valid) begin
      o_predict_taken = table_q[lookup_idx][CTR_BITS-1];
    end
  end

  // Saturating next value for the counter being updated.
  always_comb begin
    update_ctr      = table_q[update_idx];
    update_ctr_next = update_ctr;
    if (i_update_taken) begin
      if (update_ctr != CTR_MAX) update_ctr_next = update_ctr + 1'b1;
    end else begin
      if (update_ctr != '0) update_ctr_next = update_ctr - 1'b1;
    end
  end

  // Pattern table: reset to weakly not-taken, trained by resolved branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (MODE != 0 && i_update_valid) begin
      table_q[update_idx] <= update_ctr_next;
    end
  end

  // Global history: non-speculative, shifted only by resolved branches.
  // The index above uses the value from before this shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (MODE == 2 && i_update_valid) begin
      ghr_q <= GHR_BITS'({ghr_q, i_update_taken});
    end
  end

  // Event counters, saturating at all-ones and active in every mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_lookup_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (i_lookup_valid && o_lookup_count != '1) begin
        o_lookup_count <= o_lookup_count + 32'd1;
      end
      if (i_update_valid && i_update_mispredict && o_mispredict_count != '1) begin
        o_mispredict_count <= o_mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: one instance per mode, all on shared stimulus.
// Expectations are queued when stimulus is driven and popped at sampling.
module tb_branch_predictor;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        lkp_valid;
  logic [31:0] lkp_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mp;
  logic        pred0, pred1, pred2;
  logic [31:0] lc0, lc1, lc2;
  logic [31:0] mc0, mc1, mc2;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_lookups = 0;
  int   m_misp = 0;

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6), .CTR_BITS(2), .MODE(0), .GHR_BITS(6)) u_bp0 (
    .clk(clk), .rst_n(rst_n), .i_lookup_valid(lkp_valid), .i_lookup_pc(lkp_pc),
    .o_predict_taken(pred0), .i_update_valid(upd_valid), .i_update_pc(upd_pc),
    .i_update_taken(upd_taken), .i_update_mispredict(upd_mp),
    .o_lookup_count(lc0), .o_mispredict_count(mc0));

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6), .CTR_BITS(2), .MODE(1), .GHR_BITS(6)) u_bp1 (
    .clk(clk), .rst_n(rst_n), .i_lookup_valid(lkp_valid), .i_lookup_pc(lkp_pc),
    .o_predict_taken(pred1), .i_update_valid(upd_valid), .i_update_pc(upd_pc),
    .i_update_taken(upd_taken), .i_update_mispredict(upd_mp),
    .o_lookup_count(lc1), .o_mispredict_count(mc1));

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6), .CTR_BITS(2), .MODE(2), .GHR_BITS(6)) u_bp2 (
    .clk(clk), .rst_n(rst_n), .i_lookup_valid(lkp_valid), .i_lookup_pc(lkp_pc),
    .o_predict_taken(pred2), .i_update_valid(upd_valid), .i_update_pc(upd_pc),
    .i_update_taken(upd_taken), .i_update_mispredict(upd_mp),
    .o_lookup_count(lc2), .o_mispredict_count(mc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; lkp_valid = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lookups = 0; m_misp = 0;
  endtask

  // One update, applied at the next rising edge.
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic mp);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_mp = mp;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    if (mp) m_misp++;
  endtask

  // Lookup presented and withdrawn between edges, so it is not counted.
  task automatic probe(input logic [31:0] pc, output logic p0, output logic p1, output logic p2);
    @(negedge clk);
    lkp_valid = 1'b1; lkp_pc = pc; #1;
    p0 = pred0; p1 = pred1; p2 = pred2;
    lkp_valid = 1'b0;
  endtask

  // Lookup held across a rising edge, so it is counted.
  task automatic count_lookup(input logic [31:0] pc, output logic p0);
    @(negedge clk);
    lkp_valid = 1'b1; lkp_pc = pc; #1;
    p0 = pred0;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    m_lookups++;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] obs;
    lkp_valid = 1'b1; lkp_pc = 32'h40;
    exp_q.push_back('{"rst_lookup_count", 32'd0});
    exp_q.push_back('{"rst_mispredict_count", 32'd0});
    exp_q.push_back('{"rst_pred_bimodal", 32'd0});
    exp_q.push_back('{"rst_pred_gshare", 32'd0});
    #1;
    obs = lc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = mc2; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = {31'd0, pred1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = {31'd0, pred2}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    lkp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic p0, p1, p2;
      exp_q.push_back('{"post_rst_pred", 32'd0});
      probe(32'h40, p0, p1, p2);
      obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    end
  endtask

  task automatic test_train();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    apply_reset();
    do_update(32'h40, 1'b1, 1'b0);
    do_update(32'h40, 1'b1, 1'b0);
    exp_q.push_back('{"train_tt_pred", 32'd1});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    do_update(32'h40, 1'b0, 1'b0);
    exp_q.push_back('{"train_ttn_pred", 32'd1});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    do_update(32'h40, 1'b0, 1'b0);
    exp_q.push_back('{"train_ttnn_pred", 32'd0});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_saturate();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    logic [3:0] seen;
    apply_reset();
    for (int i = 0; i < 5; i++) do_update(32'h80, 1'b1, 1'b0);
    // Expected prediction after each not-taken: ctr 2,1,0,0,0.
    for (int i = 0; i < 5; i++) begin
      do_update(32'h80, 1'b0, 1'b0);
      exp_q.push_back('{$sformatf("sat_nt%0d_pred", i + 1), (i == 0) ? 32'd1 : 32'd0});
      probe(32'h80, p0, p1, p2);
      obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    end
    // Floor holds at 0: one taken reaches 1 (not-taken), a second reaches 2.
    seen = '0;
    do_update(32'h80, 1'b1, 1'b0);
    probe(32'h80, p0, p1, p2); seen[0] = p1;
    do_update(32'h80, 1'b1, 1'b0);
    probe(32'h80, p0, p1, p2); seen[1] = p1;
    exp_q.push_back('{"sat_floor_recover", 32'b10});
    obs = {30'd0, seen[1:0]}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_gshare();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    apply_reset();
    // Entries 0 and 1 reach 2, entry 3 reaches 0; history becomes 6'b000110.
    do_update(32'h0, 1'b1, 1'b0);
    do_update(32'h0, 1'b1, 1'b0);
    do_update(32'h0, 1'b0, 1'b0);
    exp_q.push_back('{"gshare_pc18_pred", 32'd1});
    exp_q.push_back('{"bimodal_pc18_pred", 32'd0});
    probe(32'h18, p0, p1, p2);
    obs = {31'd0, p2}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"gshare_pc0_pred", 32'd0});
    probe(32'h0, p0, p1, p2);
    obs = {31'd0, p2}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_same_cycle();
    exp_t e; logic [31:0] obs;
    apply_reset();
    @(negedge clk);
    lkp_valid = 1'b1; lkp_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_mp = 1'b0;
    exp_q.push_back('{"same_cycle_pre", 32'd0});
    #1;
    obs = {31'd0, pred1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"same_cycle_next", 32'd1});
    @(posedge clk); #1;
    upd_valid = 1'b0;
    m_lookups++;
    obs = {31'd0, pred1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    lkp_valid = 1'b0;
    exp_q.push_back('{"same_cycle_lookup_count", 32'(m_lookups)});
    obs = lc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    apply_reset();
    // Both PCs alias onto the entry of 0x40.
    do_update(32'h0000_1043, 1'b1, 1'b0);
    do_update(32'hFFFF_FF40, 1'b1, 1'b0);
    exp_q.push_back('{"alias_pred", 32'd1});
    exp_q.push_back('{"neighbour_pred", 32'd0});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    probe(32'h44, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    // Update fields without valid must be ignored.
    @(negedge clk);
    upd_valid = 1'b0; upd_pc = 32'h40; upd_taken = 1'b0; upd_mp = 1'b1;
    @(posedge clk); #1;
    do_update(32'h40, 1'b0, 1'b0);
    exp_q.push_back('{"ignored_update_pred", 32'd1});
    exp_q.push_back('{"ignored_update_misp", 32'd0});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = mc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_mode0();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    logic any_taken;
    apply_reset();
    for (int i = 0; i < 3; i++) do_update(32'h40, 1'b1, 1'b1);
    any_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      count_lookup(32'h40 + 32'(4 * (i % 3)), p0);
      any_taken |= p0;
    end
    exp_q.push_back('{"mode0_any_taken", 32'd0});
    obs = {31'd0, any_taken}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"mode0_lookup_count", 32'(m_lookups)});
    obs = lc0; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"mode0_mispredict_count", 32'(m_misp)});
    obs = mc0; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"mode2_lookup_count", 32'd10});
    obs = lc2; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    exp_q.push_back('{"mode0_vs_mode1_pred", 32'b01});
    probe(32'h40, p0, p1, p2);
    obs = {30'd0, p0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  task automatic test_async_reset();
    exp_t e; logic [31:0] obs; logic p0, p1, p2;
    apply_reset();
    do_update(32'h40, 1'b1, 1'b1);
    do_update(32'h40, 1'b1, 1'b1);
    count_lookup(32'h40, p0);
    exp_q.push_back('{"pre_async_misp", 32'd2});
    obs = mc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    // Reset lands between edges; outputs must clear before the next edge.
    #2;
    rst_n = 1'b0; lkp_valid = 1'b1; lkp_pc = 32'h40;
    exp_q.push_back('{"async_lookup_count", 32'd0});
    exp_q.push_back('{"async_misp_count", 32'd0});
    exp_q.push_back('{"async_pred", 32'd0});
    #1;
    obs = lc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = mc1; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    obs = {31'd0, pred1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    // An update presented while reset is held must be discarded.
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_mp = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lookups = 0; m_misp = 0;
    exp_q.push_back('{"reset_update_discarded", 32'd0});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
    // Weakly not-taken start: a single taken update flips the prediction.
    do_update(32'h40, 1'b1, 1'b0);
    exp_q.push_back('{"weak_init_one_taken", 32'd1});
    probe(32'h40, p0, p1, p2);
    obs = {31'd0, p1}; e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.val) begin n_bad++; $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val); end
  endtask

  initial begin
    rst_n = 1'b0;
    lkp_valid = 1'b0; lkp_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mp = 1'b0;
    test_reset();
    test_train();
    test_saturate();
    test_gshare();
    test_same_cycle();
    test_back_to_back();
    test_mode0();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, 32, width of instruction address.
REQ-002 SHALL have parameter INDEX_BITS, 6, log2 of pattern-table entries (64).
REQ-003 SHALL have parameter CTR_BITS, 2, saturating-counter width per entry (legal 1..4).
REQ-004 SHALL have parameter MODE, 1, 0=static not-taken, 1=bimodal, 2=gshare.
REQ-005 SHALL have parameter GHR_BITS, 6, global history length (used in MODE 2; must be <= INDEX_BITS).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port i_lookup_valid  input  1  ID stage presents a branch/jump for prediction.
REQ-009 SHALL have port i_lookup_pc  input  PC_WIDTH  PC of the instruction being predicted.
REQ-010 SHALL have port o_predict_taken  output  1  prediction for i_lookup_pc, combinational.
REQ-011 SHALL have port i_update_valid  input  1  resolved branch retires its outcome this cycle.
REQ-012 SHALL have port i_update_pc  input  PC_WIDTH  PC of the resolved branch.
REQ-013 SHALL have port i_update_taken  input  1  actual outcome.
REQ-014 SHALL have port i_update_mispredict  input  1  resolved outcome differed from prediction.
REQ-015 SHALL have port o_lookup_count  output  32  saturating count of accepted lookups.
REQ-016 SHALL have port o_mispredict_count  output  32  saturating count of mispredictions.

Function
REQ-017 Table SHALL hold 2^INDEX_BITS counters of CTR_BITS each; prediction = counter MSB.
REQ-018 Index SHALL be pc[INDEX_BITS+1:2] in MODE 1; in MODE 2, same bits XOR zero-extended GHR.
REQ-019 o_predict_taken SHALL be 0 when i_lookup_valid=0 or MODE=0, independent of table state.
REQ-020 Lookup SHALL be zero-latency combinational read of the registered table.
REQ-021 On clk edge with i_update_valid=1 and MODE!=0: counter at update index increments if taken, decrements if not.
REQ-022 Counter SHALL saturate at 2^CTR_BITS-1 and 0; no wrap-around.
REQ-023 In MODE 2 update index SHALL use GHR value before the same-edge history shift.
REQ-024 In MODE 2 on update, GHR SHALL shift left by one with i_update_taken entering bit 0; history is non-speculative.
REQ-025 Simultaneous lookup and update to same index: lookup SHALL return pre-update value; new value visible next cycle; no bypass.
REQ-026 Only one update per cycle; i_update_* ignored when i_update_valid=0.
REQ-027 o_lookup_count SHALL increment on each edge with i_lookup_valid=1; hold at 0xFFFFFFFF.
REQ-028 o_mispredict_count SHALL increment on each edge with i_update_valid=1 and i_update_mispredict=1; hold at 0xFFFFFFFF.
REQ-029 Counters SHALL count in all MODEs, including MODE 0.
REQ-030 PC bits [1:0] and bits above index field SHALL not affect indexing (aliasing permitted).

Reset
REQ-031 rst_n=0 SHALL immediately set every table entry to weakly not-taken (2^(CTR_BITS-1)-1), GHR to 0, both count outputs to 0.
REQ-032 o_predict_taken SHALL read 0 during and immediately after reset.
REQ-033 Reset asserted mid-update SHALL discard the update; no partial state survives.
REQ-034 Reset deassertion SHALL be synchronised externally; first effective update is first rising edge with rst_n=1.

Verification
REQ-035 MODE1, CTR_BITS=2: reset, update pc=0x40 taken x2 -> lookup pc=0x40 predicts 1 (counter 3); one not-taken -> still 1 (counter 2); second not-taken -> 0.
REQ-036 MODE1: 5 taken updates to pc=0x80 then 5 not-taken -> counter saturates at 3 then 0; prediction 0 after the 2nd not-taken, no wrap.
REQ-037 MODE2, GHR_BITS=6: updates taken,taken,not-taken on pc=0x0 -> GHR=0b000110; lookup pc=0x18 indexes entry 6^6=0.
REQ-038 Same-cycle lookup+update pc=0x40 from counter 1, taken -> lookup returns 0 that cycle, 1 next cycle.
REQ-039 MODE0: 10 lookups, 3 mispredict updates -> o_predict_taken always 0, o_lookup_count=10, o_mispredict_count=3.
REQ-040 Assert rst_n=0 asynchronously after training pc=0x40 to 3 -> counts 0 and prediction 0 before next clk edge.
